// File: rtl/tensor_buffer_pkg.sv
// Shared types and index helpers for the ping-pong tensor operand buffer.
// Matrices are stored row-major.
package tensor_buffer_pkg;

   typedef enum logic {
      FILLING = 1'b0,
      FULL    = 1'b1
   } load_state_e;

   function automatic int idx_row(input int idx, input int dim);
      return idx / dim;
   endfunction

   function automatic int idx_col(input int idx, input int dim);
      return idx % dim;
   endfunction

endpackage

// File: rtl/tensor_matrix_bank.sv
// One MATRIX_DIM x MATRIX_DIM storage bank. It has a single-element write port,
// a whole-matrix write port and a combinational whole-matrix read port.
module tensor_matrix_bank #(
   parameter int  DATA_WIDTH = 8,
   parameter int  MATRIX_DIM = 4,
   localparam int RW         = $clog2(MATRIX_DIM)
) (
   input  logic                                             clk,
   input  logic                                             rst_n,
   input  logic                                             elem_we_in,
   input  logic [RW-1:0]                                    elem_row_in,
   input  logic [RW-1:0]                                    elem_col_in,
   input  logic [DATA_WIDTH-1:0]                            elem_data_in,
   input  logic                                             bulk_we_in,
   input  logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] bulk_data_in,
   output logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] bulk_data_out
);

   logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] mem_q;
   logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] mem_d;

   // The top never enables both ports on the same bank, so the order here is arbitrary.
   always_comb begin
      mem_d = mem_q;
      if (bulk_we_in) begin
         mem_d = bulk_data_in;
      end else if (elem_we_in) begin
         mem_d[elem_row_in][elem_col_in] = elem_data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign bulk_data_out = mem_q;

endmodule

// File: rtl/tensor_operand_buffer.sv
// Ping-pong operand store for the tensor core. The loader streams elements into
// the shadow bank. The core reads and writes the active bank, and a swap exchanges the two.
module tensor_operand_buffer
   import tensor_buffer_pkg::*;
#(
   parameter int  DATA_WIDTH = 8,
   parameter int  MATRIX_DIM = 4,
   localparam int N          = MATRIX_DIM * MATRIX_DIM,
   localparam int AW         = $clog2(N),
   localparam int RW         = $clog2(MATRIX_DIM)
) (
   input  logic                                             clock_in,
   input  logic                                             reset_n_in,
   input  logic                                             load_valid_in,
   input  logic signed [DATA_WIDTH-1:0]                     load_data_in,
   output logic                                             load_ready_out,
   output logic                                             load_full_out,
   input  logic                                             load_clear_in,
   input  logic                                             swap_req_in,
   output logic                                             swap_ack_out,
   input  logic                                             transpose_in,
   output logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] bulk_read_data_out,
   input  logic                                             result_write_enable_in,
   input  logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] result_data_in,
   input  logic [AW-1:0]                                    read_addr_in,
   output logic signed [DATA_WIDTH-1:0]                     read_data_out
);

   load_state_e                state_q, state_d;
   logic [AW-1:0]              fill_cnt_q, fill_cnt_d;
   logic                       active_sel_q, active_sel_d;
   logic                       swap_ack_q, swap_ack_d;
   logic [DATA_WIDTH-1:0]      read_data_q, read_data_d;

   logic                       load_accept;
   logic                       swap_accept;
   logic [RW-1:0]              fill_row, fill_col;
   logic [RW-1:0]              rd_row, rd_col;

   logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] bank_mat [2];
   logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] active_mat;

   // Clear beats both load and swap. A result write holds off the swap by one cycle.
   assign load_accept = load_valid_in && (state_q == FILLING) && !load_clear_in;
   assign swap_accept = swap_req_in && (state_q == FULL) && !result_write_enable_in
                        && !load_clear_in;

   assign fill_row = RW'(idx_row(int'(fill_cnt_q), MATRIX_DIM));
   assign fill_col = RW'(idx_col(int'(fill_cnt_q), MATRIX_DIM));
   assign rd_row   = RW'(idx_row(int'(read_addr_in), MATRIX_DIM));
   assign rd_col   = RW'(idx_col(int'(read_addr_in), MATRIX_DIM));

   for (genvar b = 0; b < 2; b++) begin : g_bank
      tensor_matrix_bank #(
         .DATA_WIDTH (DATA_WIDTH),
         .MATRIX_DIM (MATRIX_DIM)
      ) u_bank (
         .clk           (clock_in),
         .rst_n         (reset_n_in),
         .elem_we_in    (load_accept && (active_sel_q != 1'(b))),
         .elem_row_in   (fill_row),
         .elem_col_in   (fill_col),
         .elem_data_in  (load_data_in),
         .bulk_we_in    (result_write_enable_in && (active_sel_q == 1'(b))),
         .bulk_data_in  (result_data_in),
         .bulk_data_out (bank_mat[b])
      );
   end

   assign active_mat = active_sel_q ? bank_mat[1] : bank_mat[0];

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q <= FILLING;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      fill_cnt_d   = fill_cnt_q;
      active_sel_d = active_sel_q;
      if (load_clear_in) begin
         state_d    = FILLING;
         fill_cnt_d = '0;
      end else if (swap_accept) begin
         state_d      = FILLING;
         fill_cnt_d   = '0;
         active_sel_d = !active_sel_q;
      end else if (load_accept) begin
         if (fill_cnt_q == AW'(N - 1)) begin
            state_d    = FULL;
            fill_cnt_d = '0;
         end else begin
            fill_cnt_d = fill_cnt_q + AW'(1);
         end
      end
   end

   always_comb begin
      load_ready_out = (state_q == FILLING);
      load_full_out  = (state_q == FULL);
   end

   assign swap_ack_d  = swap_accept;
   assign read_data_d = active_mat[rd_row][rd_col];

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         fill_cnt_q   <= '0;
         active_sel_q <= 1'b0;
         swap_ack_q   <= 1'b0;
         read_data_q  <= '0;
      end else begin
         fill_cnt_q   <= fill_cnt_d;
         active_sel_q <= active_sel_d;
         swap_ack_q   <= swap_ack_d;
         read_data_q  <= read_data_d;
      end
   end

   always_comb begin
      bulk_read_data_out = '0;
      for (int i = 0; i < MATRIX_DIM; i++) begin
         for (int j = 0; j < MATRIX_DIM; j++) begin
            bulk_read_data_out[i][j] = transpose_in ? active_mat[j][i] : active_mat[i][j];
         end
      end
   end

   assign swap_ack_out  = swap_ack_q;
   assign read_data_out = read_data_q;

endmodule

// File: tb/tb_tensor_operand_buffer.sv
// Directed bench for tensor_operand_buffer. Stimulus queues the expected observations,
// and a monitor compares them against the DUT at each falling edge.
module tb_tensor_operand_buffer;

   logic                 clock_in = 1'b0;
   logic                 reset_n_in;
   logic                 load_valid_in;
   logic signed [7:0]    load_data_in;
   logic                 load_ready_out;
   logic                 load_full_out;
   logic                 load_clear_in;
   logic                 swap_req_in;
   logic                 swap_ack_out;
   logic                 transpose_in;
   logic [3:0][3:0][7:0] bulk_read_data_out;
   logic                 result_write_enable_in;
   logic [3:0][3:0][7:0] result_data_in;
   logic [3:0]           read_addr_in;
   logic signed [7:0]    read_data_out;

   typedef enum int {K_READY, K_FULL, K_ACK, K_BULK, K_BULK_ZERO, K_RDATA} kind_e;
   typedef struct {
      string      name;
      kind_e      kind;
      int         i;
      int         j;
      logic [7:0] exp;
   } check_t;

   check_t     exp_q[$];
   check_t     cur;
   logic [7:0] act;
   int         n_checks = 0;
   int         n_errors = 0;
   logic       stimDone = 1'b0;

   tensor_operand_buffer #(.DATA_WIDTH(8), .MATRIX_DIM(4)) dut (
      .clock_in               (clock_in),
      .reset_n_in             (reset_n_in),
      .load_valid_in          (load_valid_in),
      .load_data_in           (load_data_in),
      .load_ready_out         (load_ready_out),
      .load_full_out          (load_full_out),
      .load_clear_in          (load_clear_in),
      .swap_req_in            (swap_req_in),
      .swap_ack_out           (swap_ack_out),
      .transpose_in           (transpose_in),
      .bulk_read_data_out     (bulk_read_data_out),
      .result_write_enable_in (result_write_enable_in),
      .result_data_in         (result_data_in),
      .read_addr_in           (read_addr_in),
      .read_data_out          (read_data_out)
   );

   always #5 clock_in = ~clock_in;

   // Drive the handshake inputs and let one rising edge consume them.
   task automatic applyStimulus(input logic valid, input logic [7:0] data,
                                input logic swap, input logic clr);
      load_valid_in = valid;
      load_data_in  = data;
      swap_req_in   = swap;
      load_clear_in = clr;
      @(posedge clock_in);
      #1;
   endtask

   task automatic checkOutput(input string name, input kind_e kind, input int i,
                              input int j, input logic [7:0] exp);
      check_t c;
      c.name = name;
      c.kind = kind;
      c.i    = i;
      c.j    = j;
      c.exp  = exp;
      exp_q.push_back(c);
   endtask

   // Compare every queued expectation against the DUT at the falling edge.
   initial begin
      forever begin
         @(negedge clock_in);
         while (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            case (cur.kind)
               K_READY:     act = {7'd0, load_ready_out};
               K_FULL:      act = {7'd0, load_full_out};
               K_ACK:       act = {7'd0, swap_ack_out};
               K_BULK:      act = bulk_read_data_out[cur.i][cur.j];
               K_BULK_ZERO: act = {7'd0, (bulk_read_data_out == '0)};
               default:     act = read_data_out;
            endcase
            n_checks++;
            if (act !== cur.exp) begin
               n_errors++;
               $display("[TB] FAIL %s: got %0h, expected %0h", cur.name, act, cur.exp);
            end
         end
      end
   end

   // Watchdog: the directed sequence must finish well within this bound.
   initial begin
      #20000;
      if (!stimDone) begin
         n_errors++;
         $display("[TB] FAIL timeout: stimulus did not complete in time");
         $display("[TB] Result: errors=%0d of %0d checks", n_errors, n_checks);
         $finish;
      end
   end

   // Directed stimulus sequence following the test plan.
   initial begin
      reset_n_in             = 1'b0;
      load_valid_in          = 1'b0;
      load_data_in           = '0;
      load_clear_in          = 1'b0;
      swap_req_in            = 1'b0;
      transpose_in           = 1'b0;
      result_write_enable_in = 1'b0;
      result_data_in         = '0;
      read_addr_in           = '0;

      applyStimulus(0, 0, 0, 0);
      checkOutput("rst_ready", K_READY, 0, 0, 8'd1);
      checkOutput("rst_full", K_FULL, 0, 0, 8'd0);
      checkOutput("rst_ack", K_ACK, 0, 0, 8'd0);
      checkOutput("rst_bulk", K_BULK_ZERO, 0, 0, 8'd1);
      checkOutput("rst_rdata", K_RDATA, 0, 0, 8'd0);
      applyStimulus(0, 0, 0, 0);
      reset_n_in = 1'b1;
      applyStimulus(0, 0, 0, 0);

      $display("[TB] fill 1..16 and first swap");
      for (int k = 1; k <= 15; k++) applyStimulus(1, 8'(k), 0, 0);
      checkOutput("fill15_full", K_FULL, 0, 0, 8'd0);
      checkOutput("fill15_ready", K_READY, 0, 0, 8'd1);
      applyStimulus(1, 8'd16, 0, 0);
      checkOutput("fill16_full", K_FULL, 0, 0, 8'd1);
      checkOutput("fill16_ready", K_READY, 0, 0, 8'd0);
      checkOutput("fill16_bulk_zero", K_BULK_ZERO, 0, 0, 8'd1);
      checkOutput("pre_swap_ack", K_ACK, 0, 0, 8'd0);
      applyStimulus(1, 8'd99, 1, 0);
      checkOutput("swap1_ack", K_ACK, 0, 0, 8'd1);
      checkOutput("swap1_b00", K_BULK, 0, 0, 8'd1);
      checkOutput("swap1_b33", K_BULK, 3, 3, 8'd16);
      checkOutput("swap1_ready", K_READY, 0, 0, 8'd1);
      read_addr_in = 4'd5;
      applyStimulus(0, 0, 0, 0);
      checkOutput("swap1_ack_drop", K_ACK, 0, 0, 8'd0);
      checkOutput("rd_addr5", K_RDATA, 0, 0, 8'd6);
      transpose_in = 1'b1;
      checkOutput("tr_b01", K_BULK, 0, 1, 8'd5);
      checkOutput("tr_b10", K_BULK, 1, 0, 8'd2);
      checkOutput("tr_b23", K_BULK, 2, 3, 8'd15);
      checkOutput("tr_rdata", K_RDATA, 0, 0, 8'd6);
      applyStimulus(0, 0, 0, 0);
      transpose_in = 1'b0;

      $display("[TB] swap raised with last element");
      for (int k = 0; k < 15; k++) applyStimulus(1, 8'(101 + k), 0, 0);
      applyStimulus(1, 8'd116, 1, 0);
      checkOutput("late_swap_noack", K_ACK, 0, 0, 8'd0);
      applyStimulus(0, 0, 1, 0);
      checkOutput("late_swap_ack", K_ACK, 0, 0, 8'd1);
      checkOutput("late_swap_b00", K_BULK, 0, 0, 8'd101);
      checkOutput("late_swap_b33", K_BULK, 3, 3, 8'd116);
      applyStimulus(0, 0, 0, 0);
      checkOutput("late_swap_ack_drop", K_ACK, 0, 0, 8'd0);

      $display("[TB] result write defers swap");
      read_addr_in = 4'd5;
      for (int k = 0; k < 16; k++) applyStimulus(1, 8'(21 + k), 0, 0);
      result_write_enable_in = 1'b1;
      result_data_in         = {16{8'hFD}};
      applyStimulus(0, 0, 1, 0);
      result_write_enable_in = 1'b0;
      checkOutput("wr_defer_ack", K_ACK, 0, 0, 8'd0);
      checkOutput("wr_b00", K_BULK, 0, 0, 8'hFD);
      checkOutput("wr_b21", K_BULK, 2, 1, 8'hFD);
      checkOutput("wr_rdata_old", K_RDATA, 0, 0, 8'd106);
      applyStimulus(0, 0, 1, 0);
      checkOutput("wr_swap_ack", K_ACK, 0, 0, 8'd1);
      checkOutput("wr_swap_b00", K_BULK, 0, 0, 8'd21);
      checkOutput("wr_swap_b33", K_BULK, 3, 3, 8'd36);
      checkOutput("wr_rdata_new", K_RDATA, 0, 0, 8'hFD);
      applyStimulus(0, 0, 0, 0);
      checkOutput("wr_rdata_bank1", K_RDATA, 0, 0, 8'd26);
      checkOutput("wr_ack_drop", K_ACK, 0, 0, 8'd0);

      $display("[TB] clear mid-fill");
      for (int k = 0; k < 7; k++) applyStimulus(1, 8'(51 + k), 0, 0);
      applyStimulus(1, 8'd99, 0, 1);
      checkOutput("clr_ready", K_READY, 0, 0, 8'd1);
      checkOutput("clr_full", K_FULL, 0, 0, 8'd0);
      for (int k = 0; k < 15; k++) applyStimulus(1, 8'(70 + k), 0, 0);
      checkOutput("clr15_full", K_FULL, 0, 0, 8'd0);
      applyStimulus(1, 8'd85, 0, 0);
      checkOutput("clr16_full", K_FULL, 0, 0, 8'd1);
      applyStimulus(0, 0, 1, 0);
      checkOutput("clr_swap_ack", K_ACK, 0, 0, 8'd1);
      checkOutput("clr_b00", K_BULK, 0, 0, 8'd70);
      checkOutput("clr_b13", K_BULK, 1, 3, 8'd77);
      checkOutput("clr_b33", K_BULK, 3, 3, 8'd85);
      applyStimulus(0, 0, 0, 0);

      $display("[TB] asynchronous reset mid-fill");
      for (int k = 0; k < 5; k++) applyStimulus(1, 8'(k + 1), 0, 0);
      #1;
      reset_n_in = 1'b0;
      #1;
      n_checks++;
      if (load_ready_out !== 1'b1 || load_full_out !== 1'b0 || swap_ack_out !== 1'b0
          || read_data_out !== 8'sd0 || bulk_read_data_out !== '0) begin
         n_errors++;
         $display("[TB] FAIL arst_immediate: outputs not at reset values right after reset");
      end
      checkOutput("arst_ready", K_READY, 0, 0, 8'd1);
      checkOutput("arst_full", K_FULL, 0, 0, 8'd0);
      checkOutput("arst_ack", K_ACK, 0, 0, 8'd0);
      checkOutput("arst_rdata", K_RDATA, 0, 0, 8'd0);
      checkOutput("arst_bulk", K_BULK_ZERO, 0, 0, 8'd1);
      applyStimulus(0, 0, 0, 0);
      reset_n_in   = 1'b1;
      read_addr_in = 4'd5;
      applyStimulus(0, 0, 0, 0);
      checkOutput("post_rst_rdata", K_RDATA, 0, 0, 8'd0);
      checkOutput("post_rst_bulk", K_BULK_ZERO, 0, 0, 8'd1);
      checkOutput("post_rst_ready", K_READY, 0, 0, 8'd1);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);

      stimDone = 1'b1;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("[TB] FAIL pending: %0d expectations never compared", exp_q.size());
      end
      $display("[TB] Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
